scmp_trace_capture: RTL

SCMP_TRACE_CAPTURE -- requirements
Module: scmp_trace_capture

---
 rtl/scmp_trace_capture_if.sv | 47 ++++
 rtl/scmp_trace_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_trace_capture_if.sv
`default_nettype none
// ============================================================================
// scmp_trace_capture_if : SC/MP bus probe, capture control and byte stream
// Revision: 1.0
// ============================================================================
interface scmp_trace_capture_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] sample_len;
   logic             ads_n;
   logic             rd_n;
   logic             wr_n;
   logic [7:0]       d_i;
   logic [7:0]       d_o;
   logic             cpu_rst_n;
   logic             sb;
   logic             sa;
   logic [3:0]       addr_hi;
   logic             s_h;
   logic             s_d;
   logic             s_i;
   logic             s_r;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [7:0]       drop_cnt;

   modport master (
      output start, stop, sample_len, ads_n, rd_n, wr_n, d_i, d_o,
             cpu_rst_n, sb, sa, out_ready,
      input  addr_hi, s_h, s_d, s_i, s_r, out_data, out_valid,
             busy, done, overflow, drop_cnt
   );

   modport slave (
      input  start, stop, sample_len, ads_n, rd_n, wr_n, d_i, d_o,
             cpu_rst_n, sb, sa, out_ready,
      output addr_hi, s_h, s_d, s_i, s_r, out_data, out_valid,
             busy, done, overflow, drop_cnt
   );
endinterface
`default_nettype wire

// File: rtl/scmp_trace_capture.sv
`default_nettype none
// ============================================================================
// scmp_trace_capture : samples the SC/MP bus into a FIFO and streams it out
// Revision: 1.0
// ============================================================================
module scmp_trace_capture #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  wire logic           clk,
   input  wire logic           rst,
   scmp_trace_capture_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SER_IDLE = 2'd0,
      SER_LOAD = 2'd1,
      SER_DATA = 2'd2,
      SER_CTL  = 2'd3
   } ser_t;

   state_t           state_q;
   ser_t             ser_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] len_q;
   logic             busy_q;
   logic             done_q;
   logic             overflow_q;
   logic [7:0]       drop_cnt_q;
   logic [3:0]       addr_hi_q;
   logic             s_h_q;
   logic             s_d_q;
   logic             s_i_q;
   logic             s_r_q;
   logic [15:0]      mem_q [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [15:0]      entry_q;
   logic [7:0]       out_data_q;
   logic             out_valid_q;

   logic [7:0]       sample_data_d;
   logic [7:0]       sample_ctl_d;
   logic             sample_en_d;
   logic             fifo_empty_d;
   logic             fifo_full_d;
   logic             pop_d;
   logic             push_d;
   logic             drop_d;
   logic [CNT_W-1:0] cnt_d;
   logic             last_d;
   logic [15:0]      head_d;

   always_comb begin
      sample_data_d = 8'hFF;
      if (!bus.rd_n) begin
         sample_data_d = bus.d_i;
      end else if (!bus.ads_n || !bus.wr_n) begin
         sample_data_d = bus.d_o;
      end
   end

   // s_i_q is the pre-edge value, so the same-edge status load is not visible here
   assign sample_ctl_d = {1'b1, bus.cpu_rst_n, s_i_q, bus.sb, bus.sa, 1'b0, bus.ads_n, 1'b1};
   assign sample_en_d  = (state_q == S_CAPTURE);

   assign fifo_empty_d = (wr_ptr_q == rd_ptr_q);
   assign fifo_full_d  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_d       = mem_q[rd_ptr_q[AW-1:0]];

   assign pop_d  = !fifo_empty_d &&
                   ((ser_q == SER_IDLE) || ((ser_q == SER_CTL) && bus.out_ready));
   assign push_d = sample_en_d && (!fifo_full_d || pop_d);
   assign drop_d = sample_en_d && !push_d;
   assign cnt_d  = cnt_q + 1'b1;
   assign last_d = (cnt_d == len_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  cnt_q      <= '0;
                  len_q      <= bus.sample_len;
                  done_q     <= 1'b0;
                  overflow_q <= 1'b0;
                  drop_cnt_q <= 8'd0;
                  busy_q     <= 1'b1;
                  state_q    <= (bus.sample_len == '0) ? S_DRAIN : S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               cnt_q <= cnt_d;
               if (drop_d) begin
                  overflow_q <= 1'b1;
                  if (drop_cnt_q != 8'hFF) begin
                     drop_cnt_q <= drop_cnt_q + 8'd1;
                  end
               end
               if (bus.stop || last_d) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fifo_empty_d && (ser_q == SER_IDLE)) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {s_h_q, s_d_q, s_i_q, s_r_q, addr_hi_q} <= 8'd0;
      end else if (!bus.ads_n) begin
         {s_h_q, s_d_q, s_i_q, s_r_q, addr_hi_q} <= bus.d_o;
      end
   end

   always_ff @(posedge clk) begin
      if (push_d) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {sample_data_d, sample_ctl_d};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_d) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_d) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Back-to-back entries reload straight from the FIFO head on the ctl handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         ser_q       <= SER_IDLE;
         entry_q     <= 16'd0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
      end else begin
         case (ser_q)
            SER_IDLE: begin
               if (pop_d) begin
                  entry_q <= head_d;
                  ser_q   <= SER_LOAD;
               end
            end
            SER_LOAD: begin
               out_valid_q <= 1'b1;
               out_data_q  <= entry_q[15:8];
               ser_q       <= SER_DATA;
            end
            SER_DATA: begin
               if (bus.out_ready) begin
                  out_data_q <= entry_q[7:0];
                  ser_q      <= SER_CTL;
               end
            end
            SER_CTL: begin
               if (bus.out_ready) begin
                  if (pop_d) begin
                     entry_q    <= head_d;
                     out_data_q <= head_d[15:8];
                     ser_q      <= SER_DATA;
                  end else begin
                     out_valid_q <= 1'b0;
                     ser_q       <= SER_IDLE;
                  end
               end
            end
            default: begin
               ser_q <= SER_IDLE;
            end
         endcase
      end
   end

   assign bus.addr_hi   = addr_hi_q;
   assign bus.s_h       = s_h_q;
   assign bus.s_d       = s_d_q;
   assign bus.s_i       = s_i_q;
   assign bus.s_r       = s_r_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.overflow  = overflow_q;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire
